// File: rtl/intr_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : intr_ctrl_if
//  Brief    : Signal bundle between the interrupt sources / core and the
//             intr_ctrl block. The controller uses the slave modport; the
//             core-side (or bench) uses the master modport.
//  Revision : 1.0 - initial release
// ============================================================================
interface intr_ctrl_if #(
    parameter int N_SRC = 8,
    parameter int ID_W  = 3
);
    logic [N_SRC-1:0] irq_src;
    logic [N_SRC-1:0] edge_mode;
    logic             mask_wr;
    logic [N_SRC-1:0] mask_wdata;
    logic             int_ack;
    logic             int_eoi;
    logic             interrupter;
    logic [ID_W-1:0]  int_id;
    logic [N_SRC-1:0] pending;
    logic             in_service;

    // Core / source side: drives requests and the handshake.
    modport master (
        output irq_src, edge_mode, mask_wr, mask_wdata, int_ack, int_eoi,
        input  interrupter, int_id, pending, in_service
    );

    // Controller side.
    modport slave (
        input  irq_src, edge_mode, mask_wr, mask_wdata, int_ack, int_eoi,
        output interrupter, int_id, pending, in_service
    );
endinterface
`default_nettype wire

// File: rtl/intr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : intr_ctrl
//  Brief    : Fixed-priority (lowest index wins) interrupt controller with
//             per-source mask and edge/level selection, and a
//             request / ack / end-of-interrupt handshake towards the core.
//             Optional macro INTR_CTRL_SYNC_EN inserts a 2-flop synchroniser
//             on every irq_src bit (adds 2 cycles of latency).
//  Revision : 1.0 - initial release
// ============================================================================
module intr_ctrl #(
    parameter int N_SRC = 8,
    parameter int ID_W  = 3
) (
    input  wire logic  clk,
    input  wire logic  rst,
    intr_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_SERVICE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [N_SRC-1:0] r_prev;
    logic [N_SRC-1:0] r_pending;
    logic [N_SRC-1:0] r_mask;
    logic             r_irq;
    logic [ID_W-1:0]  r_id;
    logic             r_insvc;

    logic [N_SRC-1:0] w_src;
    logic [N_SRC-1:0] w_rise;
    logic [N_SRC-1:0] w_clr;
    logic [N_SRC-1:0] w_pend_nxt;
    logic [N_SRC-1:0] w_elig;
    logic             w_any;
    logic [ID_W-1:0]  w_win;
    logic             w_id_elig;
    logic             w_ack_fire;
    logic             w_irq_nxt;
    logic [ID_W-1:0]  w_id_nxt;
    logic             w_insvc_nxt;

`ifdef INTR_CTRL_SYNC_EN
    logic [N_SRC-1:0] r_sync1;
    logic [N_SRC-1:0] r_sync2;

    // Two-flop synchroniser for asynchronous interrupt sources.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= bus.irq_src;
            r_sync2 <= r_sync1;
        end
    end

    assign w_src = r_sync2;
`else
    assign w_src = bus.irq_src;
`endif

    assign w_rise     = w_src & ~r_prev;
    assign w_ack_fire = (r_state == S_REQ) && bus.int_ack;
    assign w_elig     = r_pending & ~r_mask;
    assign w_any      = |w_elig;

    // Per-bit pending update: edge bits set on rise (set beats ack-clear),
    // level bits simply follow the sampled source.
    always_comb begin
        w_clr      = '0;
        w_pend_nxt = '0;
        for (int i = 0; i < N_SRC; i++) begin
            w_clr[i] = w_ack_fire && (r_id == ID_W'(i));
            if (bus.edge_mode[i])
                w_pend_nxt[i] = w_rise[i] | (r_pending[i] & ~w_clr[i]);
            else
                w_pend_nxt[i] = w_src[i];
        end
    end

    // Lowest-index eligible source wins; also tests whether the frozen id
    // is still eligible (used for withdraw in REQ).
    always_comb begin
        w_win     = '0;
        w_id_elig = 1'b0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (w_elig[i])
                w_win = ID_W'(i);
        end
        for (int i = 0; i < N_SRC; i++) begin
            if (r_id == ID_W'(i))
                w_id_elig = w_elig[i];
        end
    end

    // Handshake FSM: next state and next registered output values.
    always_comb begin
        w_state_nxt = r_state;
        w_irq_nxt   = r_irq;
        w_id_nxt    = r_id;
        w_insvc_nxt = r_insvc;
        case (r_state)
            S_IDLE: begin
                w_irq_nxt   = 1'b0;
                w_insvc_nxt = 1'b0;
                if (w_any) begin
                    w_state_nxt = S_REQ;
                    w_irq_nxt   = 1'b1;
                    w_id_nxt    = w_win;
                end
            end
            S_REQ: begin
                // Ack wins over a simultaneous withdraw.
                if (bus.int_ack) begin
                    w_state_nxt = S_SERVICE;
                    w_irq_nxt   = 1'b0;
                    w_insvc_nxt = 1'b1;
                end else if (!w_id_elig) begin
                    w_state_nxt = S_IDLE;
                    w_irq_nxt   = 1'b0;
                end
            end
            S_SERVICE: begin
                w_irq_nxt   = 1'b0;
                w_insvc_nxt = 1'b1;
                if (bus.int_eoi) begin
                    w_state_nxt = S_IDLE;
                    w_insvc_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_irq_nxt   = 1'b0;
                w_insvc_nxt = 1'b0;
            end
        endcase
    end

    // State, source history, mask, pending and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_prev    <= '0;
            r_pending <= '0;
            r_mask    <= '0;
            r_irq     <= 1'b0;
            r_id      <= '0;
            r_insvc   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_prev    <= w_src;
            r_pending <= w_pend_nxt;
            if (bus.mask_wr)
                r_mask <= bus.mask_wdata;
            r_irq     <= w_irq_nxt;
            r_id      <= w_id_nxt;
            r_insvc   <= w_insvc_nxt;
        end
    end

    assign bus.interrupter = r_irq;
    assign bus.int_id      = r_id;
    assign bus.pending     = r_pending;
    assign bus.in_service  = r_insvc;

endmodule
`default_nettype wire

// File: tb/tb_intr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_intr_ctrl
//  Brief    : Self-checking bench for intr_ctrl. Expected request ids are
//             queued when a source is stimulated and popped when the
//             controller raises interrupter.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_intr_ctrl;

`ifdef INTR_CTRL_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   exp_q[$];
    logic prev_irq;

    intr_ctrl_if #(.N_SRC(8), .ID_W(3)) bus ();

    intr_ctrl #(.N_SRC(8), .ID_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every rising request must match the next queued id.
    always @(negedge clk) begin
        if (bus.interrupter === 1'b1 && prev_irq !== 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_request: got unexpected request id %0d, expected none", bus.int_id);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (bus.int_id !== 3'(e)) begin
                    n_fail++;
                    $display("FAIL sb_id: got id %0d expected %0d", bus.int_id, e);
                end
            end
        end
        prev_irq = bus.interrupter;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse one edge source for a cycle and advance to the cycle where
    // interrupter should be high.
    task automatic pulse_to_req(input int id);
        exp_q.push_back(id);
        bus.irq_src[id] = 1'b1;
        tick();
        bus.irq_src[id] = 1'b0;
        repeat (LAT) tick();
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.interrupter, bus.int_id, bus.in_service, bus.pending} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_async: got irq=%0b id=%0d svc=%0b pend=%h expected all 0",
                     bus.interrupter, bus.int_id, bus.in_service, bus.pending);
        end
        repeat (2) tick();
        rst = 1'b0;
        tick();
        n_checks++;
        if ({bus.interrupter, bus.int_id, bus.in_service, bus.pending} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_release: got irq=%0b id=%0d svc=%0b pend=%h expected all 0",
                     bus.interrupter, bus.int_id, bus.in_service, bus.pending);
        end
    endtask

    task automatic test_single_edge();
        exp_q.push_back(5);
        bus.irq_src[5] = 1'b1;
        tick();
        bus.irq_src[5] = 1'b0;
        repeat (LAT) tick();
        n_checks++;
        if (bus.pending !== 8'h20 || bus.interrupter !== 1'b0) begin
            n_fail++;
            $display("FAIL single_pending: got pend=%h irq=%0b expected pend=20 irq=0", bus.pending, bus.interrupter);
        end
        tick();
        n_checks++;
        if (bus.interrupter !== 1'b1 || bus.int_id !== 3'd5) begin
            n_fail++;
            $display("FAIL single_req: got irq=%0b id=%0d expected irq=1 id=5", bus.interrupter, bus.int_id);
        end
        bus.int_ack = 1'b1;
        tick();
        bus.int_ack = 1'b0;
        n_checks++;
        if (bus.interrupter !== 1'b0 || bus.in_service !== 1'b1 || bus.pending !== 8'h00) begin
            n_fail++;
            $display("FAIL single_ack: got irq=%0b svc=%0b pend=%h expected irq=0 svc=1 pend=00",
                     bus.interrupter, bus.in_service, bus.pending);
        end
        bus.int_eoi = 1'b1;
        tick();
        bus.int_eoi = 1'b0;
        tick();
        n_checks++;
        if (bus.interrupter !== 1'b0 || bus.in_service !== 1'b0) begin
            n_fail++;
            $display("FAIL single_eoi: got irq=%0b svc=%0b expected 0 0", bus.interrupter, bus.in_service);
        end
    endtask

    task automatic test_priority();
        exp_q.push_back(2);
        exp_q.push_back(6);
        bus.irq_src = 8'h44;
        tick();
        bus.irq_src = 8'h00;
        repeat (LAT) tick();
        tick();
        n_checks++;
        if (bus.interrupter !== 1'b1 || bus.int_id !== 3'd2) begin
            n_fail++;
            $display("FAIL prio_first: got irq=%0b id=%0d expected irq=1 id=2", bus.interrupter, bus.int_id);
        end
        bus.int_ack = 1'b1;
        tick();
        bus.int_ack = 1'b0;
        repeat (2) tick();
        n_checks++;
        if (bus.in_service !== 1'b1 || bus.pending !== 8'h40 || bus.interrupter !== 1'b0) begin
            n_fail++;
            $display("FAIL prio_queued: got svc=%0b pend=%h irq=%0b expected svc=1 pend=40 irq=0",
                     bus.in_service, bus.pending, bus.interrupter);
        end
        bus.int_eoi = 1'b1;
        tick();
        bus.int_eoi = 1'b0;
        n_checks++;
        if (bus.interrupter !== 1'b0 || bus.in_service !== 1'b0) begin
            n_fail++;
            $display("FAIL prio_gap: got irq=%0b svc=%0b expected 0 0", bus.interrupter, bus.in_service);
        end
        tick();
        n_checks++;
        if (bus.interrupter !== 1'b1 || bus.int_id !== 3'd6) begin
            n_fail++;
            $display("FAIL prio_second: got irq=%0b id=%0d expected irq=1 id=6", bus.interrupter, bus.int_id);
        end
        bus.int_ack = 1'b1;
        tick();
        bus.int_ack = 1'b0;
        bus.int_eoi = 1'b1;
        tick();
        bus.int_eoi = 1'b0;
        tick();
        n_checks++;
        if (bus.pending !== 8'h00 || bus.interrupter !== 1'b0) begin
            n_fail++;
            $display("FAIL prio_drain: got pend=%h irq=%0b expected 00 0", bus.pending, bus.interrupter);
        end
    endtask

    task automatic test_level_vs_edge();
        // Level mode: held source re-requests after eoi.
        bus.edge_mode = 8'hF7;
        exp_q.push_back(3);
        exp_q.push_back(3);
        bus.irq_src[3] = 1'b1;
        tick();
        repeat (LAT) tick();
        tick();
        bus.int_ack = 1'b1;
        tick();
        bus.int_ack = 1'b0;
        n_checks++;
        if (bus.in_service !== 1'b1 || bus.pending[3] !== 1'b1) begin
            n_fail++;
            $display("FAIL level_ack: got svc=%0b pend3=%0b expected 1 1", bus.in_service, bus.pending[3]);
        end
        bus.int_eoi = 1'b1;
        tick();
        bus.int_eoi = 1'b0;
        n_checks++;
        if (bus.interrupter !== 1'b0) begin
            n_fail++;
            $display("FAIL level_idle: got irq=%0b expected 0", bus.interrupter);
        end
        tick();
        n_checks++;
        if (bus.interrupter !== 1'b1 || bus.int_id !== 3'd3) begin
            n_fail++;
            $display("FAIL level_rereq: got irq=%0b id=%0d expected irq=1 id=3", bus.interrupter, bus.int_id);
        end
        // Dropping the level withdraws the request.
        bus.irq_src[3] = 1'b0;
        repeat (LAT + 2) tick();
        n_checks++;
        if (bus.interrupter !== 1'b0 || bus.pending !== 8'h00 || bus.in_service !== 1'b0) begin
            n_fail++;
            $display("FAIL level_withdraw: got irq=%0b pend=%h svc=%0b expected 0 00 0",
                     bus.interrupter, bus.pending, bus.in_service);
        end
        // Edge mode, same stimulus: one request only.
        bus.edge_mode = 8'hFF;
        exp_q.push_back(3);
        bus.irq_src[3] = 1'b1;
        tick();
        repeat (LAT) tick();
        tick();
        bus.int_ack = 1'b1;
        tick();
        bus.int_ack = 1'b0;
        bus.int_eoi = 1'b1;
        tick();
        bus.int_eoi = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (bus.interrupter !== 1'b0 || bus.pending !== 8'h00) begin
            n_fail++;
            $display("FAIL edge_norereq: got irq=%0b pend=%h expected 0 00", bus.interrupter, bus.pending);
        end
        bus.irq_src[3] = 1'b0;
        repeat (LAT + 2) tick();
    endtask

    task automatic test_mask_withdraw();
        exp_q.push_back(1);
        pulse_to_req(1);
        bus.mask_wdata = 8'h02;
        bus.mask_wr    = 1'b1;
        tick();
        bus.mask_wr    = 1'b0;
        tick();
        n_checks++;
        if (bus.interrupter !== 1'b0 || bus.pending[1] !== 1'b1 || bus.in_service !== 1'b0) begin
            n_fail++;
            $display("FAIL mask_withdraw: got irq=%0b pend1=%0b svc=%0b expected 0 1 0",
                     bus.interrupter, bus.pending[1], bus.in_service);
        end
        tick();
        n_checks++;
        if (bus.interrupter !== 1'b0) begin
            n_fail++;
            $display("FAIL mask_hold: got irq=%0b expected 0", bus.interrupter);
        end
        bus.mask_wdata = 8'h00;
        bus.mask_wr    = 1'b1;
        tick();
        bus.mask_wr    = 1'b0;
        tick();
        n_checks++;
        if (bus.interrupter !== 1'b1 || bus.int_id !== 3'd1) begin
            n_fail++;
            $display("FAIL unmask_rereq: got irq=%0b id=%0d expected irq=1 id=1", bus.interrupter, bus.int_id);
        end
        bus.int_ack = 1'b1;
        tick();
        bus.int_ack = 1'b0;
        bus.int_eoi = 1'b1;
        tick();
        bus.int_eoi = 1'b0;
        tick();
    endtask

    task automatic test_protocol_and_reset();
        bus.int_eoi = 1'b1;
        tick();
        bus.int_eoi = 1'b0;
        tick();
        n_checks++;
        if (bus.interrupter !== 1'b0 || bus.in_service !== 1'b0 || bus.pending !== 8'h00) begin
            n_fail++;
            $display("FAIL eoi_in_idle: got irq=%0b svc=%0b pend=%h expected 0 0 00",
                     bus.interrupter, bus.in_service, bus.pending);
        end
        pulse_to_req(4);
        bus.int_ack = 1'b1;
        tick();
        bus.int_ack = 1'b0;
        bus.int_ack = 1'b1;
        tick();
        bus.int_ack = 1'b0;
        n_checks++;
        if (bus.in_service !== 1'b1 || bus.interrupter !== 1'b0 || bus.int_id !== 3'd4) begin
            n_fail++;
            $display("FAIL ack_in_service: got svc=%0b irq=%0b id=%0d expected 1 0 4",
                     bus.in_service, bus.interrupter, bus.int_id);
        end
        bus.int_eoi = 1'b1;
        tick();
        bus.int_eoi = 1'b0;
        tick();
        // Reset while a request is outstanding.
        pulse_to_req(0);
        n_checks++;
        if (bus.interrupter !== 1'b1 || bus.int_id !== 3'd0) begin
            n_fail++;
            $display("FAIL pre_reset_req: got irq=%0b id=%0d expected 1 0", bus.interrupter, bus.int_id);
        end
        bus.irq_src[7] = 1'b1;
        tick();
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.interrupter, bus.int_id, bus.in_service, bus.pending} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_in_req: got irq=%0b id=%0d svc=%0b pend=%h expected all 0",
                     bus.interrupter, bus.int_id, bus.in_service, bus.pending);
        end
        bus.irq_src = 8'h00;
        tick();
        rst = 1'b0;
        repeat (LAT + 3) tick();
        n_checks++;
        if (bus.interrupter !== 1'b0 || bus.pending !== 8'h00) begin
            n_fail++;
            $display("FAIL post_reset: got irq=%0b pend=%h expected 0 00", bus.interrupter, bus.pending);
        end
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        prev_irq       = 1'b0;
        rst            = 1'b1;
        bus.irq_src    = '0;
        bus.edge_mode  = 8'hFF;
        bus.mask_wr    = 1'b0;
        bus.mask_wdata = '0;
        bus.int_ack    = 1'b0;
        bus.int_eoi    = 1'b0;

        test_reset();
        test_single_edge();
        test_priority();
        test_level_vs_edge();
        test_mask_withdraw();
        test_protocol_and_reset();

        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d outstanding requests expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
